countdown_timer: RTL and testbench

Programmable down-counter that counts a loaded value toward zero at a selectable tick rate. It flags expiry when the count reaches zero. It is the counting-down counterpart of the lab up-counter and uses the same four rate selections and parallel-load semantics. q drives the existing hex display decoder; done and expired feed board LEDs or downstream control.

---
 rtl/countdown_timer_pkg.sv | 32 +++
 rtl/countdown_timer_tick_gen.sv | 61 ++++++
 rtl/countdown_timer.sv | 186 ++++++++++++++++++
 tb/tb_countdown_timer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/countdown_timer_pkg.sv
// ---------------------------------------------------------------------------
// countdown_timer_pkg
//
// Shared definitions for the countdown timer:
//   cd_state_e  - 2-bit FSM state encoding (IDLE=00, RUN=01, HOLD=10,
//                 EXPIRED=11). The encoding is visible on the state_dbg
//                 output, so external checkers can decode it.
//   DEF_RATE0..3 - default divider terminal values for the four rate
//                  selections. The timer divides by (RATEn + 1).
// ---------------------------------------------------------------------------
package countdown_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUN     = 2'b01,
        ST_HOLD    = 2'b10,
        ST_EXPIRED = 2'b11
    } cd_state_e;

    // Default rates assume a 50 MHz board clock.
    localparam int unsigned DEF_RATE0 = 0;            // tick every cycle
    localparam int unsigned DEF_RATE1 = 49_999_999;   // 1 Hz
    localparam int unsigned DEF_RATE2 = 99_999_999;   // 0.5 Hz
    localparam int unsigned DEF_RATE3 = 199_999_999;  // 0.25 Hz

    // Busy covers both counting states. A paused timer is still
    // committed to a count.
    function automatic logic state_is_busy(input cd_state_e st);
        return (st == ST_RUN) || (st == ST_HOLD);
    endfunction

endpackage

// File: rtl/countdown_timer_tick_gen.sv
// ---------------------------------------------------------------------------
// countdown_timer_tick_gen
//
// Programmable tick divider. It holds a DIV_W-bit down-counter.
//   - reload : load load_val into the divider (highest priority after reset)
//   - enable : count this cycle. When the divider is at zero and enable is
//              high, tick fires and the divider reloads load_val.
//   - When neither reload nor enable is high, the divider holds its value.
//     This is how a paused or idle timer keeps its place.
//
// A tick therefore occurs every (load_val + 1) enabled cycles. load_val is
// sampled only on a reload, so a new rate applies from the next reload.
//
// Ports:
//   clk      in   1      system clock, rising edge
//   clear_b  in   1      synchronous active-low reset (divider -> 0)
//   reload   in   1      load load_val this edge
//   enable   in   1      divider counts this cycle
//   load_val in   DIV_W  terminal value to load
//   tick     out  1      divider at zero while enabled (combinational)
// ---------------------------------------------------------------------------
module countdown_timer_tick_gen #(
    parameter int DIV_W = 28
) (
    input  logic             clk,
    input  logic             clear_b,
    input  logic             reload,
    input  logic             enable,
    input  logic [DIV_W-1:0] load_val,
    output logic             tick
);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    assign tick = enable && (div_q == '0);

    always_comb begin
        div_d = div_q;
        if (reload) begin
            div_d = load_val;
        end else if (enable) begin
            // Reloading on the tick edge makes the tick period exactly
            // load_val + 1 cycles, with no gap cycle between periods.
            if (tick) begin
                div_d = load_val;
            end else begin
                div_d = div_q - DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!clear_b) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// ---------------------------------------------------------------------------
// countdown_timer
//
// Programmable down-counter. A value is loaded in parallel and counted toward
// zero at one of four tick rates. Expiry is flagged when the count reaches
// zero.
//
// The priority at each clock edge is: clear_b > parload > start > pause > tick.
//
// FSM:
//   IDLE    - waiting. parload loads q. start goes to RUN, or goes
//             directly to EXPIRED if q is already zero.
//   RUN     - the divider counts. Each tick decrements q. The tick that
//             takes q from 1 (or 0 after a load of zero) ends in EXPIRED.
//   HOLD    - paused. q and the divider are frozen.
//   EXPIRED - q is 0. Only parload (back to IDLE) or reset leaves this state.
//
// Ports:
//   clk       in   1      system clock, rising edge
//   clear_b   in   1      synchronous active-low reset
//   sel       in   2      rate select, sampled on every divider reload
//   d         in   CNT_W  parallel load value
//   parload   in   1      level: load d into q
//   start     in   1      level: begin counting from IDLE
//   pause     in   1      level: freeze count and divider while high
//   q         out  CNT_W  current count (registered)
//   busy      out  1      high in RUN or HOLD
//   expired   out  1      high in EXPIRED
//   done      out  1      one-cycle pulse on the edge entering EXPIRED
//   state_dbg out  2      current FSM state, for debug and checkers
// ---------------------------------------------------------------------------
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int          CNT_W = 4,
    parameter int          DIV_W = 28,
    parameter int unsigned RATE0 = DEF_RATE0,
    parameter int unsigned RATE1 = DEF_RATE1,
    parameter int unsigned RATE2 = DEF_RATE2,
    parameter int unsigned RATE3 = DEF_RATE3
) (
    input  logic             clk,
    input  logic             clear_b,
    input  logic [1:0]       sel,
    input  logic [CNT_W-1:0] d,
    input  logic             parload,
    input  logic             start,
    input  logic             pause,
    output logic [CNT_W-1:0] q,
    output logic             busy,
    output logic             expired,
    output logic             done,
    output cd_state_e        state_dbg
);

    cd_state_e        state_q;
    cd_state_e        state_d;
    logic [CNT_W-1:0] q_q;
    logic [CNT_W-1:0] q_d;
    logic             done_q;
    logic             done_d;

    logic [DIV_W-1:0] rate_val;
    logic             div_reload;
    logic             div_enable;
    logic             tick;

    // Rate mux. sel is consumed by the divider only when it reloads.
    always_comb begin
        rate_val = DIV_W'(RATE0);
        case (sel)
            2'b00:   rate_val = DIV_W'(RATE0);
            2'b01:   rate_val = DIV_W'(RATE1);
            2'b10:   rate_val = DIV_W'(RATE2);
            default: rate_val = DIV_W'(RATE3);
        endcase
    end

    // The divider reloads on a real start from IDLE, or on parload while a
    // count is in progress. A parload in IDLE/EXPIRED leaves the divider
    // alone, because the next start reloads it anyway.
    always_comb begin
        div_reload = 1'b0;
        if (parload) begin
            div_reload = state_is_busy(state_q);
        end else if (start) begin
            div_reload = (state_q == ST_IDLE) && (q_q != '0);
        end
    end

    // The divider advances only when running and nothing higher-priority
    // claims the edge. This keeps the divider frozen for the whole of a
    // pause, including the edge that enters HOLD.
    assign div_enable = (state_q == ST_RUN) && !parload && !pause;

    countdown_timer_tick_gen #(
        .DIV_W (DIV_W)
    ) u_tick_gen (
        .clk      (clk),
        .clear_b  (clear_b),
        .reload   (div_reload),
        .enable   (div_enable),
        .load_val (rate_val),
        .tick     (tick)
    );

    // Next-state and count logic. The branches are ordered to match the
    // input priority: parload, then start, then pause, then tick.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (parload) begin
                    q_d = d;
                end else if (start) begin
                    if (q_q == '0) begin
                        state_d = ST_EXPIRED;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                if (parload) begin
                    q_d = d;
                end else if (pause) begin
                    state_d = ST_HOLD;
                end else if (tick) begin
                    // The count saturates at zero. A load of zero while
                    // running therefore expires on the next tick.
                    if (q_q <= CNT_W'(1)) begin
                        q_d     = '0;
                        state_d = ST_EXPIRED;
                        done_d  = 1'b1;
                    end else begin
                        q_d = q_q - CNT_W'(1);
                    end
                end
            end

            ST_HOLD: begin
                if (parload) begin
                    q_d = d;
                end else if (!pause) begin
                    state_d = ST_RUN;
                end
            end

            ST_EXPIRED: begin
                if (parload) begin
                    q_d     = d;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                q_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clear_b) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            done_q  <= done_d;
        end
    end

    assign q         = q_q;
    assign busy      = state_is_busy(state_q);
    assign expired   = (state_q == ST_EXPIRED);
    assign done      = done_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;
    import countdown_timer_pkg::*;

    localparam int CNT_W = 4;
    localparam int DIV_W = 28;
    localparam int unsigned R0 = 0;
    localparam int unsigned R1 = 9;
    localparam int unsigned R2 = 3;
    localparam int unsigned R3 = 5;

    // ---------------- clock / reset ----------------
    logic             clk = 1'b0;
    logic             clear_b;
    logic [1:0]       sel;
    logic [CNT_W-1:0] d;
    logic             parload;
    logic             start;
    logic             pause;
    logic [CNT_W-1:0] q;
    logic             busy;
    logic             expired;
    logic             done;
    cd_state_e        state_dbg;

    always #5 clk = ~clk;

    countdown_timer #(
        .CNT_W (CNT_W),
        .DIV_W (DIV_W),
        .RATE0 (R0),
        .RATE1 (R1),
        .RATE2 (R2),
        .RATE3 (R3)
    ) dut (
        .clk       (clk),
        .clear_b   (clear_b),
        .sel       (sel),
        .d         (d),
        .parload   (parload),
        .start     (start),
        .pause     (pause),
        .q         (q),
        .busy      (busy),
        .expired   (expired),
        .done      (done),
        .state_dbg (state_dbg)
    );

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Mode names are the bench's own. The timer is modelled as "edges left
    // until the next decrement": start or load arms (rate+1), each unpaused
    // running edge consumes one, and reaching zero decrements q.
    localparam int M_IDLE = 0, M_RUN = 1, M_HOLD = 2, M_EXP = 3;
    int          m_mode = M_IDLE;
    int unsigned m_q    = 0;
    int unsigned m_wait = 0;
    bit          m_done = 1'b0;

    function automatic int unsigned period_of(input logic [1:0] s);
        case (s)
            2'd0:    return R0 + 1;
            2'd1:    return R1 + 1;
            2'd2:    return R2 + 1;
            default: return R3 + 1;
        endcase
    endfunction

    function automatic cd_state_e mode_to_state(input int m);
        case (m)
            M_RUN:   return ST_RUN;
            M_HOLD:  return ST_HOLD;
            M_EXP:   return ST_EXPIRED;
            default: return ST_IDLE;
        endcase
    endfunction

    always @(posedge clk) begin
        m_done = 1'b0;
        if (!clear_b) begin
            m_mode = M_IDLE;
            m_q    = 0;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    if (parload) m_q = d;
                    else if (start) begin
                        if (m_q == 0) begin
                            m_mode = M_EXP;
                            m_done = 1'b1;
                        end else begin
                            m_mode = M_RUN;
                            m_wait = period_of(sel);
                        end
                    end
                end
                M_RUN: begin
                    if (parload) begin
                        m_q    = d;
                        m_wait = period_of(sel);
                    end else if (pause) begin
                        m_mode = M_HOLD;
                    end else begin
                        m_wait = m_wait - 1;
                        if (m_wait == 0) begin
                            if (m_q <= 1) begin
                                m_q    = 0;
                                m_mode = M_EXP;
                                m_done = 1'b1;
                            end else begin
                                m_q    = m_q - 1;
                                m_wait = period_of(sel);
                            end
                        end
                    end
                end
                M_HOLD: begin
                    if (parload) begin
                        m_q    = d;
                        m_wait = period_of(sel);
                    end else if (!pause) begin
                        m_mode = M_RUN;
                    end
                end
                default: begin
                    if (parload) begin
                        m_q    = d;
                        m_mode = M_IDLE;
                    end
                end
            endcase
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_q",       32'(q),         m_q);
            check("model_busy",    32'(busy),      32'((m_mode == M_RUN) || (m_mode == M_HOLD)));
            check("model_expired", 32'(expired),   32'(m_mode == M_EXP));
            check("model_done",    32'(done),      32'(m_done));
            check("model_state",   32'(state_dbg), 32'(mode_to_state(m_mode)));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic clr, input logic pl, input logic st,
                         input logic pa, input logic [1:0] s, input logic [CNT_W-1:0] dv);
        clear_b = clr;
        parload = pl;
        start   = st;
        pause   = pa;
        sel     = s;
        d       = dv;
    endtask

    // Advance one edge. Outputs are settled and inputs can be changed on return.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // 1. reset with random other inputs
        drive(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 4'($urandom));
        step();
        drive(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 4'($urandom));
        step();
        cmp_en = 1'b1;
        check("rst_q", 32'(q), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_expired", 32'(expired), 0);
        check("rst_done", 32'(done), 0);
        check("rst_state", 32'(state_dbg), 32'(ST_IDLE));

        // 2. basic countdown at sel=00
        drive(1, 1, 0, 0, 2'd0, 4'd3); step();
        drive(1, 0, 1, 0, 2'd0, 4'd3); step();          // edge k
        drive(1, 0, 0, 0, 2'd0, 4'd3);
        check("t2_q_k", 32'(q), 3);
        check("t2_busy_k", 32'(busy), 1);
        step(); check("t2_q_k1", 32'(q), 2);
        step(); check("t2_q_k2", 32'(q), 1);
        step(); check("t2_q_k3", 32'(q), 0);
        check("t2_expired_k3", 32'(expired), 1);
        check("t2_done_k3", 32'(done), 1);
        step(); check("t2_done_k4", 32'(done), 0);
        check("t2_expired_k4", 32'(expired), 1);

        // 3. pause at q=3
        drive(1, 1, 0, 0, 2'd0, 4'd5); step();
        drive(1, 0, 1, 0, 2'd0, 4'd5); step();          // edge k
        drive(1, 0, 0, 0, 2'd0, 4'd5);
        step(); check("t3_q_k1", 32'(q), 4);
        step(); check("t3_q_k2", 32'(q), 3);
        drive(1, 0, 0, 1, 2'd0, 4'd5);
        step(); check("t3_hold_q1", 32'(q), 3); check("t3_hold_busy1", 32'(busy), 1);
        check("t3_hold_state", 32'(state_dbg), 32'(ST_HOLD));
        step(); check("t3_hold_q2", 32'(q), 3); check("t3_hold_busy2", 32'(busy), 1);
        drive(1, 0, 0, 0, 2'd0, 4'd5);
        step(); check("t3_resume_q", 32'(q), 3);
        step(); check("t3_q2", 32'(q), 2);
        step(); check("t3_q1", 32'(q), 1);
        step(); check("t3_q0", 32'(q), 0); check("t3_done", 32'(done), 1);

        // 4. zero load and ignored start in EXPIRED
        drive(1, 1, 0, 0, 2'd0, 4'd0); step();
        check("t4_idle_expired", 32'(expired), 0);
        drive(1, 0, 1, 0, 2'd0, 4'd0); step();
        check("t4_zero_expired", 32'(expired), 1);
        check("t4_zero_done", 32'(done), 1);
        step();
        check("t4_restart_done", 32'(done), 0);
        check("t4_restart_expired", 32'(expired), 1);
        drive(1, 1, 0, 0, 2'd0, 4'd7); step();
        check("t4_reload_q", 32'(q), 7);
        check("t4_reload_expired", 32'(expired), 0);
        check("t4_reload_state", 32'(state_dbg), 32'(ST_IDLE));

        // 5. divider rate sel=01 (RATE1=9)
        drive(1, 1, 0, 0, 2'd1, 4'd2); step();
        drive(1, 0, 1, 0, 2'd1, 4'd2); step();          // edge k
        drive(1, 0, 0, 0, 2'd1, 4'd2);
        for (int i = 1; i <= 9; i++) begin
            step(); check("t5_q_hold2", 32'(q), 2);
        end
        step(); check("t5_q_k10", 32'(q), 1);
        for (int i = 11; i <= 19; i++) begin
            step(); check("t5_q_hold1", 32'(q), 1);
        end
        step(); check("t5_q_k20", 32'(q), 0); check("t5_done_k20", 32'(done), 1);

        // 6. abort mid-run, then load+start conflict in IDLE
        drive(1, 1, 0, 0, 2'd0, 4'd5); step();
        drive(1, 0, 1, 0, 2'd0, 4'd5); step();
        drive(1, 0, 0, 0, 2'd0, 4'd5);
        step(); check("t6_q4", 32'(q), 4);
        drive(0, 0, 0, 0, 2'd0, 4'd5);
        step(); check("t6_abort_q", 32'(q), 0);
        check("t6_abort_state", 32'(state_dbg), 32'(ST_IDLE));
        check("t6_abort_done", 32'(done), 0);
        drive(1, 1, 1, 0, 2'd0, 4'd6);
        step(); check("t6_conf_q", 32'(q), 6);
        check("t6_conf_busy", 32'(busy), 0);
        check("t6_conf_state", 32'(state_dbg), 32'(ST_IDLE));

        // Randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            drive(1'($urandom_range(0, 63) != 0),
                  1'($urandom_range(0, 15) == 0),
                  1'($urandom_range(0, 5) == 0),
                  1'($urandom_range(0, 6) == 0),
                  2'($urandom_range(0, 3)),
                  4'($urandom_range(0, 15)));
            step();
        end

        @(negedge clk);
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
